// File: rtl/adder_seq_stage.sv
// adder_seq_stage: operand-feed and result-capture stage around an external
// ripple-carry adder. Operands are accepted over valid/ready and held on the
// adder inputs. After a programmable settle time the sum is registered and
// offered downstream over valid/ready. Completed handshakes are counted.
module adder_seq_stage #(
    parameter int DATA_W        = 10,
    parameter int SETTLE_CYCLES = 2,   // legal range 1..15
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W:0]   add_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_sum,
    output logic              out_carry,
    output logic [CNT_W-1:0]  txn_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter load value: the capture edge is SETTLE_CYCLES edges after acceptance.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       capture;
    logic       fire;

    assign accept  = in_valid && in_ready;
    assign capture = (state == SETTLE) && (settle_cnt == 4'd0);
    assign fire    = out_valid && out_ready;

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all registered state so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed
        // branch would otherwise infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // A result leaving this cycle frees the stage for new operands.
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? SETTLE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand hold registers and settle countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= '0;
            add_b      <= '0;
            settle_cnt <= 4'd0;
        end else if (accept) begin
            add_a      <= in_a;
            add_b      <= in_b;
            settle_cnt <= SETTLE_INIT;
        end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Result capture once the adder has settled; held until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else if (capture) begin
            out_sum   <= add_sum;
            out_carry <= add_sum[DATA_W];
        end
    end

    // Completed-handshake counter, wrapping silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (fire) begin
            txn_count <= txn_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_seq_stage.sv
// Bench for adder_seq_stage: two instances (settle 2 and settle 1), each fed
// by a behavioural adder, checked every cycle against a transaction-level
// model plus directed literal expectations.
module tb_adder_seq_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [9:0]  in_a      [2];
    logic [9:0]  in_b      [2];
    logic [9:0]  add_a     [2];
    logic [9:0]  add_b     [2];
    logic [10:0] add_sum   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [10:0] out_sum   [2];
    logic        out_carry [2];
    logic [7:0]  txn_count [2];

    int checks   = 0;
    int failures = 0;

    // Model state per instance
    logic        m_pend  [2];
    logic        m_valid [2];
    logic [9:0]  m_a     [2];
    logic [9:0]  m_b     [2];
    logic [10:0] m_sum   [2];
    logic [7:0]  m_cnt   [2];
    int          m_cap   [2];
    int          cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external 10-bit adder
    assign add_sum[0] = {1'b0, add_a[0]} + {1'b0, add_b[0]};
    assign add_sum[1] = {1'b0, add_a[1]} + {1'b0, add_b[1]};

    adder_seq_stage #(.DATA_W(10), .SETTLE_CYCLES(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_sum(add_sum[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_carry(out_carry[0]),
        .txn_count(txn_count[0])
    );

    adder_seq_stage #(.DATA_W(10), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_sum(add_sum[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_carry(out_carry[1]),
        .txn_count(txn_count[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Transaction-level model: accept when free, sum appears SETTLE edges later,
    // result leaves on handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i]  <= 1'b0;
                m_valid[i] <= 1'b0;
                m_a[i]     <= '0;
                m_b[i]     <= '0;
                m_sum[i]   <= '0;
                m_cnt[i]   <= '0;
                m_cap[i]   <= 0;
            end
            cyc <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic logic free_now = !m_pend[i] && (!m_valid[i] || out_ready[i]);
                automatic logic leaving  = m_valid[i] && out_ready[i];
                automatic logic taking   = in_valid[i] && free_now;
                automatic logic landing  = m_pend[i] && (cyc == m_cap[i]);
                if (landing) begin
                    m_sum[i]   <= {1'b0, m_a[i]} + {1'b0, m_b[i]};
                    m_valid[i] <= 1'b1;
                    m_pend[i]  <= 1'b0;
                end
                if (leaving) begin
                    m_cnt[i]   <= m_cnt[i] + 8'd1;
                    m_valid[i] <= 1'b0;
                end
                if (taking) begin
                    m_a[i]    <= in_a[i];
                    m_b[i]    <= in_b[i];
                    m_pend[i] <= 1'b1;
                    m_cap[i]  <= cyc + settle_of(i);
                end
            end
            cyc <= cyc + 1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic logic exp_rdy = !m_pend[i] && (!m_valid[i] || out_ready[i]);
            check($sformatf("u%0d.out_valid", i), 32'(out_valid[i]), 32'(m_valid[i]));
            check($sformatf("u%0d.in_ready", i),  32'(in_ready[i]),  32'(exp_rdy));
            check($sformatf("u%0d.out_sum", i),   32'(out_sum[i]),   32'(m_sum[i]));
            check($sformatf("u%0d.out_carry", i), 32'(out_carry[i]), 32'(m_sum[i][10]));
            check($sformatf("u%0d.add_a", i),     32'(add_a[i]),     32'(m_a[i]));
            check($sformatf("u%0d.add_b", i),     32'(add_b[i]),     32'(m_b[i]));
            check($sformatf("u%0d.txn_count", i), 32'(txn_count[i]), 32'(m_cnt[i]));
        end
    end

    // Advance exactly one rising edge; inputs set before the call apply at it.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s u%0d add_a", tag, i),     32'(add_a[i]),     32'd0);
            check($sformatf("%s u%0d add_b", tag, i),     32'(add_b[i]),     32'd0);
            check($sformatf("%s u%0d out_sum", tag, i),   32'(out_sum[i]),   32'd0);
            check($sformatf("%s u%0d out_carry", tag, i), 32'(out_carry[i]), 32'd0);
            check($sformatf("%s u%0d out_valid", tag, i), 32'(out_valid[i]), 32'd0);
            check($sformatf("%s u%0d txn_count", tag, i), 32'(txn_count[i]), 32'd0);
            check($sformatf("%s u%0d in_ready", tag, i),  32'(in_ready[i]),  32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_a[i]      = '0;
            in_b[i]      = '0;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single transaction, settle 2: 3FF + 001
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1; in_a[0] = 10'h3FF; in_b[0] = 10'h001;
        step();                                   // edge 0: accept
        in_valid[0] = 1'b0;
        step();                                   // edge 1: settling
        check("single pre-capture out_valid", 32'(out_valid[0]), 32'd0);
        step();                                   // edge 2: capture
        check("single out_valid", 32'(out_valid[0]), 32'd1);
        check("single out_sum",   32'(out_sum[0]),   32'h400);
        check("single out_carry", 32'(out_carry[0]), 32'd1);
        step();                                   // edge 3: handshake
        check("single txn_count", 32'(txn_count[0]), 32'd1);
        check("single idle out_valid", 32'(out_valid[0]), 32'd0);

        // Backpressure: 300 + 200 held for 5 cycles
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1; in_a[0] = 10'd300; in_b[0] = 10'd200;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp out_valid", 32'(out_valid[0]), 32'd1);
            check("bp out_sum",   32'(out_sum[0]),   32'd500);
            check("bp in_ready",  32'(in_ready[0]),  32'd0);
            step();
        end
        out_ready[0] = 1'b1;
        step();
        check("bp release out_valid", 32'(out_valid[0]), 32'd0);
        check("bp release txn_count", 32'(txn_count[0]), 32'd2);
        check("bp release in_ready",  32'(in_ready[0]),  32'd1);

        // Ignored input while settling
        in_valid[0] = 1'b1; in_a[0] = 10'd10; in_b[0] = 10'd20;
        step();                                   // accept 10+20
        in_a[0] = 10'h155; in_b[0] = 10'd0;
        step();                                   // in SETTLE, must ignore
        in_valid[0] = 1'b0;
        check("ignore add_a", 32'(add_a[0]), 32'd10);
        step();                                   // capture
        check("ignore out_sum", 32'(out_sum[0]), 32'd30);
        check("ignore add_a after", 32'(add_a[0]), 32'd10);
        step();                                   // handshake
        check("ignore txn_count", 32'(txn_count[0]), 32'd3);

        // Streaming on settle-1 instance
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1; in_a[1] = 10'd1; in_b[1] = 10'd2;
        step();                                   // e0 accept (1,2)
        in_a[1] = 10'd3; in_b[1] = 10'd4;
        step();                                   // e1 capture 3
        check("stream sum0", 32'(out_sum[1]), 32'd3);
        check("stream valid0", 32'(out_valid[1]), 32'd1);
        step();                                   // e2 handshake + accept (3,4)
        check("stream gap valid", 32'(out_valid[1]), 32'd0);
        in_a[1] = 10'h3FF; in_b[1] = 10'h3FF;
        step();                                   // e3 capture 7
        check("stream sum1", 32'(out_sum[1]), 32'd7);
        step();                                   // e4 handshake + accept (3FF,3FF)
        in_valid[1] = 1'b0;
        step();                                   // e5 capture 7FE
        check("stream sum2",   32'(out_sum[1]),   32'h7FE);
        check("stream carry2", 32'(out_carry[1]), 32'd1);
        step();                                   // e6 handshake
        check("stream txn_count", 32'(txn_count[1]), 32'd3);

        // Reset one cycle after acceptance aborts the transaction
        in_valid[0] = 1'b1; in_a[0] = 10'd5; in_b[0] = 10'd6;
        step();                                   // accept
        in_valid[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post-reset out_valid", 32'(out_valid[0]), 32'd0);
            check("post-reset txn_count", 32'(txn_count[0]), 32'd0);
            check("post-reset in_ready",  32'(in_ready[0]),  32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
